// File: rtl/adc_oversample_ctrl_pkg.sv
// Shared types and helpers for the ADC oversampling sequencer.
package adc_oversample_ctrl_pkg;

    localparam int DEF_B       = 8;
    localparam int DEF_MAX_OSR = 4;
    localparam int ACC_W       = DEF_B + DEF_MAX_OSR;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [2:0] clamp_osr(input logic [2:0] osr, input int max_osr);
        if (int'(osr) > max_osr) begin
            return 3'(max_osr);
        end
        return osr;
    endfunction

endpackage

// File: rtl/adc_valid_tracker.sv
// Shift register that follows issued conversions through the converter latency.
module adc_valid_tracker #(
    parameter int LAT = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    output logic o_tap,
    output logic o_empty_next
);

    logic [LAT-1:0] r_sr;
    logic [LAT-1:0] w_sr_next;

    generate
        if (LAT == 1) begin : g_single
            assign w_sr_next = i_valid;
        end else begin : g_chain
            assign w_sr_next = {r_sr[LAT-2:0], i_valid};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_tap = r_sr[LAT-1];
    // Empty after this edge, so the drain can finish on the last accumulate.
    assign o_empty_next = ~|w_sr_next;

endmodule

// File: rtl/adc_oversample_ctrl.sv
// Strobes the comparators, issues settled thermometer codes to the converter,
// accumulates 2^osr returned codes and hands out their average.
module adc_oversample_ctrl
    import adc_oversample_ctrl_pkg::*;
#(
    parameter int B       = DEF_B,
    parameter int LAT     = 6,
    parameter int SETTLE  = 3,
    parameter int MAX_OSR = DEF_MAX_OSR
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_osr_log2,
    output logic              o_busy,
    output logic              o_sample,
    input  logic [(2**B)-1:0] i_thermo_in,
    output logic              o_conv_valid,
    output logic [(2**B)-1:0] o_conv_thermo,
    input  logic [B-1:0]      i_conv_bin,
    output logic [B-1:0]      o_result,
    output logic              o_result_valid,
    input  logic              i_result_ready
);

    localparam int AW = B + MAX_OSR;
    localparam int CW = MAX_OSR + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_osr_lat;
    logic [CW-1:0]      r_issue_cnt;
    logic [SW-1:0]      r_settle_cnt;
    logic [AW-1:0]      r_acc;
    logic [AW-1:0]      w_acc_next;
    logic [B-1:0]       r_result;
    logic               r_result_valid;
    logic               r_sample;
    logic               r_conv_valid;
    logic [(2**B)-1:0]  r_conv_thermo;
    logic [2:0]         w_osr_clamped;
    logic               w_settle_last;
    logic               w_accept;
    logic               w_tap;
    logic               w_empty_next;

    adc_valid_tracker #(.LAT(LAT)) u_tracker (
        .i_clk        (i_clock),
        .i_rst        (i_reset),
        .i_valid      (r_conv_valid),
        .o_tap        (w_tap),
        .o_empty_next (w_empty_next)
    );

    assign w_osr_clamped = clamp_osr(i_osr_log2, MAX_OSR);
    assign w_accept      = (r_state == ST_IDLE) && i_start;
    assign w_settle_last = (r_state == ST_SETTLE) && (r_settle_cnt == SW'(SETTLE - 1));
    assign w_acc_next    = r_acc + (w_tap ? AW'(i_conv_bin) : '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_SETTLE;
            ST_SETTLE: if (w_settle_last) w_next = (r_issue_cnt == CW'(1)) ? ST_DRAIN : ST_SAMPLE;
            ST_DRAIN:  if (w_empty_next) w_next = ST_DONE;
            ST_DONE:   if (i_result_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_osr_lat      <= '0;
            r_issue_cnt    <= '0;
            r_settle_cnt   <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_sample       <= 1'b0;
            r_conv_valid   <= 1'b0;
            r_conv_thermo  <= '0;
        end else begin
            r_sample     <= (w_next == ST_SAMPLE);
            r_conv_valid <= w_settle_last;
            if (w_settle_last) begin
                r_conv_thermo <= i_thermo_in;
                r_issue_cnt   <= r_issue_cnt - 1'b1;
            end
            if ((r_state == ST_SETTLE) && !w_settle_last) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end
            if (w_accept) begin
                r_osr_lat   <= w_osr_clamped;
                r_issue_cnt <= CW'(1) << w_osr_clamped;
                r_acc       <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
            // The final add and the result capture share one edge.
            if ((r_state == ST_DRAIN) && w_empty_next) begin
                r_result       <= B'(w_acc_next >> r_osr_lat);
                r_result_valid <= 1'b1;
            end else if ((r_state == ST_DONE) && i_result_ready) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign o_sample       = r_sample;
    assign o_conv_valid   = r_conv_valid;
    assign o_conv_thermo  = r_conv_thermo;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_adc_oversample_ctrl.sv
// Directed bench for adc_oversample_ctrl with a cycle-level timing model and a
// behavioural converter.
module tb_adc_oversample_ctrl;

    localparam int B   = 8;
    localparam int TW  = 256;
    localparam int LAT = 6;
    localparam int S   = 3;
    localparam int P   = S + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    osr_log2;
    logic          busy;
    logic          sample;
    logic [TW-1:0] thermo_in;
    logic          conv_valid;
    logic [TW-1:0] conv_thermo;
    logic [B-1:0]  conv_bin;
    logic [B-1:0]  result;
    logic          result_valid;
    logic          result_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int codes[$];
    int cidx = 0;

    adc_oversample_ctrl #(.B(B), .LAT(LAT), .SETTLE(S), .MAX_OSR(4)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_osr_log2     (osr_log2),
        .o_busy         (busy),
        .o_sample       (sample),
        .i_thermo_in    (thermo_in),
        .o_conv_valid   (conv_valid),
        .o_conv_thermo  (conv_thermo),
        .i_conv_bin     (conv_bin),
        .o_result       (result),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready)
    );

    function automatic logic [TW-1:0] therm(input int n);
        logic [TW-1:0] t;
        for (int i = 0; i < TW; i++) t[i] = (i < n);
        return t;
    endfunction

    function automatic int sat_pop(input logic [TW-1:0] t);
        int c = 0;
        for (int i = 0; i < TW; i++) c += int'(t[i]);
        return (c > 255) ? 255 : c;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural converter: binary code LAT cycles after the issue, junk otherwise.
    logic [B-1:0] pb[LAT];
    logic         pv[LAT];
    initial for (int i = 0; i < LAT; i++) begin pb[i] = '0; pv[i] = 1'b0; end
    always @(posedge clk) begin
        pb[0] <= B'(sat_pop(conv_thermo));
        pv[0] <= conv_valid;
        for (int i = 1; i < LAT; i++) begin
            pb[i] <= pb[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign conv_bin = pv[LAT-1] ? pb[LAT-1] : 8'hA5;

    // Comparator front end: presents the next code once it sees the strobe.
    initial forever begin
        @(posedge clk);
        #2;
        if (sample) begin
            thermo_in = (cidx < codes.size()) ? therm(codes[cidx]) : therm(0);
            cidx++;
        end
    end

    // Timing model: every output is a function of the cycle offset from the accepted start.
    int m_busy = 0, m_t = 0, m_osr = 0, m_n = 1, m_sum = 0, m_res = 0, mc = 0;
    logic [TW-1:0] m_thermo = '0;
    initial forever begin
        int d, e_busy, e_sample, e_cv, e_rv, e_res;
        @(negedge clk);
        mc++;
        if (rst) begin
            m_busy = 0; m_res = 0; m_sum = 0; m_thermo = '0;
            check("rst_busy", busy, 0);
            check("rst_sample", sample, 0);
            check("rst_conv_valid", conv_valid, 0);
            check("rst_result_valid", result_valid, 0);
            check("rst_result", result, 0);
            check("rst_conv_thermo_zero", conv_thermo == '0, 1);
        end else begin
            d = mc - m_t;
            e_busy = m_busy; e_sample = 0; e_cv = 0; e_rv = 0; e_res = m_res;
            if (m_busy != 0) begin
                if (d >= 1 && (d - 1) % P == 0 && (d - 1) / P < m_n) e_sample = 1;
                if (d >= S + 2 && (d - S - 2) % P == 0 && (d - S - 2) / P < m_n) e_cv = 1;
                if (d >= 1 + m_n * P + LAT + 1) begin
                    e_rv = 1;
                    e_res = m_sum >> m_osr;
                end
            end
            check("busy", busy, e_busy);
            check("sample", sample, e_sample);
            check("conv_valid", conv_valid, e_cv);
            check("result_valid", result_valid, e_rv);
            check("result", result, e_res);
            checks++;
            if (conv_thermo !== m_thermo) begin
                errors++;
                $display("FAIL conv_thermo: got %h expected %h at cycle %0d", conv_thermo, m_thermo, cyc);
            end
            if (m_busy != 0) begin
                if (d >= P && d % P == 0 && d / P <= m_n) begin
                    m_thermo = thermo_in;
                    m_sum += sat_pop(thermo_in);
                end
                if (e_rv != 0 && result_ready) begin
                    m_busy = 0;
                    m_res = e_res;
                end
            end else if (start) begin
                m_busy = 1;
                m_t = mc;
                m_osr = (int'(osr_log2) > 4) ? 4 : int'(osr_log2);
                m_n = 1 << m_osr;
                m_sum = 0;
            end
        end
    end

    task automatic run_one(input int osr, input int exp_res, input int exp_lat, input string nm);
        int t0, n;
        @(posedge clk); #1;
        osr_log2 = osr[2:0];
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, cyc - t0, exp_lat);
        check({nm, "_result"}, result, exp_res);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check({nm, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int t0, n, scount, runs, last_rv;
        rst = 1'b1; start = 1'b0; osr_log2 = 3'd0; thermo_in = '0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_conv_valid", conv_valid, 0);
        rst = 1'b0;

        codes = '{37}; cidx = 0;
        run_one(0, 37, 12, "osr0");

        codes = '{10, 11, 12, 13}; cidx = 0;
        run_one(2, 11, 24, "osr2");

        codes.delete();
        for (int i = 0; i < 16; i++) codes.push_back(256);
        cidx = 0;
        run_one(7, 255, 72, "osr7_clamp");

        // Consumer stalls while start keeps arriving.
        codes = '{200}; cidx = 0;
        @(posedge clk); #1;
        osr_log2 = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            @(posedge clk); #1;
            check("hold_result", result, 200);
            check("hold_valid", result_valid, 1);
            check("hold_sample", sample, 0);
            check("hold_busy", busy, 1);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("hold_release_busy", busy, 0);

        // Reset during the drain with conversions still inside the converter.
        codes = '{100, 100, 100, 100}; cidx = 0;
        @(posedge clk); #1;
        osr_log2 = 3'd2; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 18) begin @(posedge clk); #1; end
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_sample", sample, 0);
        check("async_conv_valid", conv_valid, 0);
        check("async_result_valid", result_valid, 0);
        check("async_result", result, 0);
        check("async_conv_thermo_zero", conv_thermo == '0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        codes = '{5}; cidx = 0;
        run_one(0, 5, 12, "post_reset");

        // Back-to-back runs with start and result_ready held high.
        codes = '{3, 9, 27, 81, 243, 7, 49, 1, 2, 4}; cidx = 0;
        @(posedge clk); #1;
        osr_log2 = 3'd1; result_ready = 1'b1; start = 1'b1;
        scount = 0; runs = 0; last_rv = -1; n = 0;
        while (runs < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (sample) scount++;
            if (result_valid) begin
                check("b2b_samples", scount, 2);
                if (last_rv >= 0) check("b2b_period", cyc - last_rv, 17);
                last_rv = cyc;
                scount = 0;
                runs++;
            end
        end
        check("b2b_runs", runs, 3);
        start = 1'b0;
        @(posedge clk); #1;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
